// File: rtl/load_store_unit_if.sv
// Request, memory and response signal bundle
// for the load/store unit.
interface load_store_unit_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_store;
  logic [2:0]            req_funct3;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [31:0]           req_wdata;
  logic [ADDR_WIDTH-3:0] mem_addr;
  logic                  mem_rstrb;
  logic [3:0]            mem_wmask;
  logic [31:0]           mem_wdata;
  logic [31:0]           mem_rdata;
  logic                  mem_busy;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [31:0]           resp_rdata;
  logic                  resp_error;

  modport slave (
    input  req_valid, req_store, req_funct3,
    input  req_addr, req_wdata,
    input  mem_rdata, mem_busy, resp_ready,
    output req_ready, mem_addr, mem_rstrb,
    output mem_wmask, mem_wdata,
    output resp_valid, resp_rdata, resp_error
  );

  modport master (
    output req_valid, req_store, req_funct3,
    output req_addr, req_wdata,
    output mem_rdata, mem_busy, resp_ready,
    input  req_ready, mem_addr, mem_rstrb,
    input  mem_wmask, mem_wdata,
    input  resp_valid, resp_rdata, resp_error
  );
endinterface

// File: rtl/load_store_unit.sv
// Memory-access stage: aligns stores into byte lanes,
// extracts and extends loads, flags bad accesses.
module load_store_unit #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic CLK,
  input  logic RESET,
  load_store_unit_if.slave bus
);
  typedef enum logic [2:0] {
    IDLE, WRITE, READ, WAIT, RESP
  } state_t;

  state_t                state;
  logic                  req_ready_q;
  logic                  rstrb_q;
  logic [3:0]            wmask_q;
  logic [31:0]           wdata_q;
  logic [ADDR_WIDTH-3:0] maddr_q;
  logic                  rvalid_q;
  logic [31:0]           rdata_q;
  logic                  rerr_q;
  logic [2:0]            lat_f3;
  logic [1:0]            lat_off;

  logic        bad;
  logic        misal;
  logic [3:0]  wm_n;
  logic [31:0] wd_n;
  logic [2:0]  f3;
  logic [1:0]  off;

  assign f3  = bus.req_funct3;
  assign off = bus.req_addr[1:0];

  always_comb begin
    if (bus.req_store)
      bad = f3 > 3'd2;
    else
      bad = (f3 == 3'd3) || (f3[2:1] == 2'b11);
    wm_n  = 4'b1111;
    wd_n  = bus.req_wdata;
    misal = 1'b0;
    unique case (1'b1)
      (f3[1:0] == 2'd0): begin
        wm_n = 4'b0001 << off;
        wd_n = {4{bus.req_wdata[7:0]}};
      end
      (f3[1:0] == 2'd1): begin
        wm_n  = off[1] ? 4'b1100 : 4'b0011;
        wd_n  = {2{bus.req_wdata[15:0]}};
        misal = off[0];
      end
      default: misal = off != 2'd0;
    endcase
  end

  logic [15:0] half;
  logic [7:0]  byt;
  logic [31:0] ext;

  always_comb begin
    half = lat_off[1] ? bus.mem_rdata[31:16]
                      : bus.mem_rdata[15:0];
    byt  = lat_off[0] ? half[15:8] : half[7:0];
    unique case (1'b1)
      (lat_f3 == 3'd0): ext = {{24{byt[7]}}, byt};
      (lat_f3 == 3'd1): ext = {{16{half[15]}}, half};
      (lat_f3 == 3'd4): ext = {24'd0, byt};
      (lat_f3 == 3'd5): ext = {16'd0, half};
      default:          ext = bus.mem_rdata;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state       <= IDLE;
      req_ready_q <= 1'b1;
      rstrb_q     <= 1'b0;
      wmask_q     <= 4'd0;
      wdata_q     <= 32'd0;
      maddr_q     <= '0;
      rvalid_q    <= 1'b0;
      rdata_q     <= 32'd0;
      rerr_q      <= 1'b0;
      lat_f3      <= 3'd0;
      lat_off     <= 2'd0;
    end else begin
      unique case (state)
        IDLE: if (bus.req_valid) begin
          req_ready_q <= 1'b0;
          lat_f3      <= f3;
          lat_off     <= off;
          maddr_q     <= bus.req_addr[ADDR_WIDTH-1:2];
          wdata_q     <= wd_n;
          rdata_q     <= 32'd0;
          if (bad || misal) begin
            rerr_q   <= 1'b1;
            rvalid_q <= 1'b1;
            state    <= RESP;
          end else if (bus.req_store) begin
            wmask_q <= wm_n;
            state   <= WRITE;
          end else begin
            rstrb_q <= 1'b1;
            state   <= READ;
          end
        end
        WRITE: if (!bus.mem_busy) begin
          wmask_q  <= 4'd0;
          rvalid_q <= 1'b1;
          state    <= RESP;
        end
        READ: if (!bus.mem_busy) begin
          rstrb_q <= 1'b0;
          state   <= WAIT;
        end
        WAIT: if (!bus.mem_busy) begin
          rdata_q  <= ext;
          rvalid_q <= 1'b1;
          state    <= RESP;
        end
        RESP: if (bus.resp_ready) begin
          rvalid_q    <= 1'b0;
          rerr_q      <= 1'b0;
          rdata_q     <= 32'd0;
          req_ready_q <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.mem_addr   = maddr_q;
  assign bus.mem_rstrb  = rstrb_q;
  assign bus.mem_wmask  = wmask_q;
  assign bus.mem_wdata  = wdata_q;
  assign bus.resp_valid = rvalid_q;
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_error = rerr_q;
endmodule
